// File: rtl/reg_file_mp_pkg.sv
// Shared widths and state encodings for the multi-port register file.
package reg_file_mp_pkg;
  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int REG_FILE_SIZE     = 2 ** REG_FILE_ADDR_LEN;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;
endpackage

// File: rtl/reg_file_mp_rf_read_port.sv
// One read port: picks stored word or same-cycle write data, then applies
// the zero-register and clear-phase overrides to data and pending flag.
module rf_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = WORD_LEN,
  parameter int ADDR_W   = REG_FILE_ADDR_LEN,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              pend_bit,
  input  logic              state,
  output logic [DATA_W-1:0] data,
  output logic              pending
);
  always_comb begin
    data    = mem_word;
    pending = pend_bit;
    if (BYPASS != 0) begin
      // wr1 is evaluated last so it wins a same-address collision
      if (wr0_en && (wr0_addr == addr)) begin
        data    = wr0_data;
        pending = 1'b0;
      end
      if (wr1_en && (wr1_addr == addr)) begin
        data    = wr1_data;
        pending = 1'b0;
      end
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data    = '0;
      pending = 1'b0;
    end
    if (state == RF_CLEAR) begin
      data    = '0;
      pending = 1'b0;
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with write bypass, pending scoreboard
// and a sequential clear engine that zeroes storage after reset.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = WORD_LEN,
  parameter int ADDR_W   = REG_FILE_ADDR_LEN,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic                     init_busy
);
  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e                      state_q, state_d;
  logic [ADDR_W-1:0]              clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;
  logic [DEPTH-1:0]               pend_q, pend_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_d     = mem_q;
    pend_d    = pend_q;
    if (state_q == RF_CLEAR) begin
      mem_d[clr_cnt_q] = '0;
      clr_cnt_d        = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RF_READY;
    end else begin
      if (wr0_en) begin
        if (!((ZERO_REG != 0) && (wr0_addr == '0))) mem_d[wr0_addr] = wr0_data;
        pend_d[wr0_addr] = 1'b0;
      end
      if (wr1_en) begin
        if (!((ZERO_REG != 0) && (wr1_addr == '0))) mem_d[wr1_addr] = wr1_data;
        pend_d[wr1_addr] = 1'b0;
      end
      // a newly issued producer supersedes one retiring in the same cycle
      if (sb_set_en) pend_d[sb_set_addr] = 1'b1;
      if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // storage has no reset; the clear engine zeroes it entry by entry
  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  assign init_busy = (state_q == RF_CLEAR);

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[gi*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rp (
      .addr    (a),
      .mem_word(mem_q[a]),
      .wr0_en  (wr0_en),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_en  (wr1_en),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .pend_bit(pend_q[a]),
      .state   (state_q),
      .data    (rd_data[gi*DATA_W +: DATA_W]),
      .pending (rd_pending[gi])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and random checks of reg_file_mp (bypass and non-bypass builds
// driven in lockstep) against an array-based reference model.
module tb_reg_file_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   ra [NR];
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]   pend_b, pend_n;
  logic            busy_b, busy_n;
  logic            wr0_en, wr1_en, sb_set_en;
  logic [AW-1:0]   wr0_addr, wr1_addr, sb_set_addr;
  logic [DW-1:0]   wr0_data, wr1_data;

  assign rd_addr = {ra[1], ra[0]};
  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(pend_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .init_busy(busy_b));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(pend_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .init_busy(busy_n));

  // reference model: architectural contents, pending flags, clear cycles left
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  int            m_clear;
  int            n_asserts = 0, n_fails = 0, busy_seen;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a, bit byp);
    if (m_clear > 0 || a == 0) return '0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(logic [AW-1:0] a, bit byp);
    if (m_clear > 0 || a == 0) return 1'b0;
    if (byp && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    m_clear = DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k]  = '0;
      m_pend[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst) model_reset();
    else if (m_clear > 0) m_clear--;
    else begin
      if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
      if (wr0_en) m_pend[wr0_addr] = 1'b0;
      if (wr1_en) m_pend[wr1_addr] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rd_data_byp[%0d]", p), rd_data_b[p*DW +: DW], exp_data(ra[p], 1'b1));
      chk($sformatf("rd_data_nobyp[%0d]", p), rd_data_n[p*DW +: DW], exp_data(ra[p], 1'b0));
      chk($sformatf("rd_pend_byp[%0d]", p), DW'(pend_b[p]), DW'(exp_pend(ra[p], 1'b1)));
      chk($sformatf("rd_pend_nobyp[%0d]", p), DW'(pend_n[p]), DW'(exp_pend(ra[p], 1'b0)));
    end
    chk("init_busy", DW'(busy_b), DW'(m_clear > 0));
    chk("init_busy_nb", DW'(busy_n), DW'(m_clear > 0));
    if (busy_b === 1'b1) busy_seen++;
  endtask

  // inputs change just after negedge; outputs checked 1ns later, then commit
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ra[0] = '0; ra[1] = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // clear phase: busy for exactly DEPTH cycles, write to r3 ignored
    busy_seen = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      idle();
      if (c == 4) begin wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hCAFE_0003; end
      ra[0] = 5'd3; ra[1] = 5'(c);
      tick();
    end
    chk("busy_cycles", DW'(busy_seen), DW'(DEPTH));
    idle(); ra[0] = 5'd3; #1; chk("r3_after_clear", rd_data_b[0 +: DW], 32'h0); tick();

    // basic write and zero register
    idle(); wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF; ra[0] = 5'd5; tick();
    idle(); ra[0] = 5'd5; #1; chk("r5_read", rd_data_b[0 +: DW], 32'hDEAD_BEEF); tick();
    idle(); wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'h1234; ra[1] = 5'd0; tick();
    idle(); ra[1] = 5'd0; #1; chk("r0_zero", rd_data_b[DW +: DW], 32'h0); tick();

    // dual-write conflict on r7
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    ra[0] = 5'd7; #1; chk("r7_bypass", rd_data_b[0 +: DW], 32'h22); tick();
    idle(); ra[0] = 5'd7; #1;
    chk("r7_stored", rd_data_b[0 +: DW], 32'h22);
    chk("r7_stored_nb", rd_data_n[0 +: DW], 32'h22); tick();

    // bypass vs. no-bypass on r9
    idle(); wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hAA; tick();
    idle(); wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hBB; ra[0] = 5'd9; #1;
    chk("r9_byp_same", rd_data_b[0 +: DW], 32'hBB);
    chk("r9_nobyp_same", rd_data_n[0 +: DW], 32'hAA); tick();
    idle(); ra[0] = 5'd9; #1; chk("r9_nobyp_next", rd_data_n[0 +: DW], 32'hBB); tick();

    // scoreboard on r4
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd4; tick();
    idle(); ra[0] = 5'd4; #1; chk("r4_pend_set", DW'(pend_b[0]), 32'd1); tick();
    idle(); wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h44; ra[0] = 5'd4; #1;
    chk("r4_pend_wr_byp", DW'(pend_b[0]), 32'd0);
    chk("r4_pend_wr_nb", DW'(pend_n[0]), 32'd1); tick();
    idle(); ra[0] = 5'd4; #1; chk("r4_pend_clr", DW'(pend_n[0]), 32'd0); tick();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd4; wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h45; tick();
    idle(); ra[0] = 5'd4; #1; chk("r4_set_wins", DW'(pend_n[0]), 32'd1); tick();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd0; tick();
    idle(); ra[0] = 5'd0; #1; chk("r0_never_pend", DW'(pend_n[0]), 32'd0); tick();

    // reset in READY, then again at clear cycle 10
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin idle(); ra[0] = 5'd5; tick(); end
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin idle(); ra[0] = 5'd9; ra[1] = 5'(c); tick(); end
    chk("busy_cycles_restart", DW'(busy_seen), DW'(DEPTH));

    // random traffic with narrow address range for frequent collisions
    for (int c = 0; c < 600; c++) begin
      idle();
      rst         = ($urandom_range(0, 199) == 0);
      wr0_en      = 1'($urandom_range(0, 1));
      wr0_addr    = 5'($urandom_range(0, 9));
      wr0_data    = $urandom;
      wr1_en      = 1'($urandom_range(0, 1));
      wr1_addr    = 5'($urandom_range(0, 9));
      wr1_data    = $urandom;
      sb_set_en   = 1'($urandom_range(0, 1));
      sb_set_addr = 5'($urandom_range(0, 9));
      ra[0]       = 5'($urandom_range(0, 9));
      ra[1]       = ($urandom_range(0, 3) == 0) ? wr1_addr : 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
